conv_lmem_responder: RTL and testbench

- Synthesizable responder for the CONV layer-memory interface (csel/cwr/caddr_wr/cdata_wr/crd/caddr_rd/cdata_rd).
- Holds five banks: L0_MEM0, L0_MEM1, L1_MEM0, L1_MEM1, L2_MEM.
- Serves CONV reads and writes while busy=1.
- After the run, streams a selected bank out on a dump port for on-chip checking or host upload. Sits beside CONV and replaces the behavioural memory model.

---
 rtl/conv_mem_pkg.sv | 42 ++++
 rtl/conv_bank_sp.sv | 38 +++
 rtl/conv_lmem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_conv_lmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared constants, bank decode and dump FSM state for the CONV layer memory.
package conv_mem_pkg;

    localparam int DEF_DW       = 20;
    localparam int DEF_AW       = 12;
    localparam int DEF_L0_DEPTH = 4096;
    localparam int DEF_L1_DEPTH = 1024;
    localparam int DEF_L2_DEPTH = 2048;

    localparam logic [2:0] CSEL_L0_0 = 3'b001;
    localparam logic [2:0] CSEL_L0_1 = 3'b010;
    localparam logic [2:0] CSEL_L1_0 = 3'b011;
    localparam logic [2:0] CSEL_L1_1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    localparam int NUM_BANKS = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } dump_state_e;

    // Zero depth marks an invalid select, so "addr < depth" covers both checks.
    function automatic logic [31:0] depth_of(
        input logic [2:0]  sel,
        input logic [31:0] d0,
        input logic [31:0] d1,
        input logic [31:0] d2
    );
        logic [31:0] d;
        d = '0;
        case (sel)
            CSEL_L0_0, CSEL_L0_1: d = d0;
            CSEL_L1_0, CSEL_L1_1: d = d1;
            CSEL_L2:              d = d2;
            default:              d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/conv_bank_sp.sv
// One layer-memory bank: synchronous write, registered reads, read-before-write.
module conv_bank_sp #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
)(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re_a,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic          i_re_b,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q_a;
    logic [DW-1:0] r_q_b;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re_a) begin
            r_q_a <= r_mem[i_raddr_a];
        end
        if (i_re_b) begin
            r_q_b <= r_mem[i_raddr_b];
        end
    end

    assign o_rdata_a = r_q_a;
    assign o_rdata_b = r_q_b;

endmodule

// File: rtl/conv_lmem_responder.sv
// CONV layer-memory responder: five banks, CONV read/write port and a bank dump streamer.
module conv_lmem_responder
    import conv_mem_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int L0_DEPTH = DEF_L0_DEPTH,
    parameter int L1_DEPTH = DEF_L1_DEPTH,
    parameter int L2_DEPTH = DEF_L2_DEPTH
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          busy,
    input  logic [2:0]    csel,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    output logic          wr_l0,
    output logic          wr_l1,
    output logic          wr_l2,
    output logic          err_acc,
    input  logic          dump_start,
    input  logic [2:0]    dump_sel,
    output logic          dump_vld,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          dump_last,
    output logic          dump_abort
);

    localparam logic [31:0] D0 = 32'(L0_DEPTH);
    localparam logic [31:0] D1 = 32'(L1_DEPTH);
    localparam logic [31:0] D2 = 32'(L2_DEPTH);

    dump_state_e r_state;
    dump_state_e w_next;

    logic [2:0]    r_rd_sel;
    logic          r_wr_l0;
    logic          r_wr_l1;
    logic          r_wr_l2;
    logic          r_err;
    logic [2:0]    r_dsel;
    logic [AW-1:0] r_ptr;
    logic          r_iss_vld;
    logic [AW-1:0] r_iss_addr;
    logic          r_iss_last;
    logic          r_dump_vld;
    logic [AW-1:0] r_dump_addr;
    logic [DW-1:0] r_dump_data;
    logic          r_dump_last;
    logic          r_dump_abort;

    logic [31:0]   w_cdepth;
    logic [31:0]   w_ddepth;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_dsel_ok;
    logic          w_err;
    logic          w_start;
    logic          w_issue;
    logic          w_ptr_last;
    logic          w_abort;
    logic [DW-1:0] w_q_a [NUM_BANKS];
    logic [DW-1:0] w_q_b [NUM_BANKS];
    logic [DW-1:0] w_dq;

    assign w_cdepth   = depth_of(csel, D0, D1, D2);
    assign w_ddepth   = depth_of(r_dsel, D0, D1, D2);
    assign w_wr_ok    = cwr && (32'(caddr_wr) < w_cdepth);
    assign w_rd_ok    = crd && (32'(caddr_rd) < w_cdepth);
    assign w_dsel_ok  = depth_of(dump_sel, D0, D1, D2) != '0;
    assign w_start    = (r_state == S_IDLE) && dump_start && !busy && w_dsel_ok;
    assign w_issue    = (r_state == S_RUN) && !busy;
    assign w_ptr_last = 32'(r_ptr) == (w_ddepth - 32'd1);

    assign w_err = (cwr && !w_wr_ok)
                || (crd && !w_rd_ok)
                || ((r_state == S_IDLE) && dump_start && !w_dsel_ok);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam logic [2:0] SEL = 3'(g + 1);
        localparam int         DEP = int'(depth_of(SEL, D0, D1, D2));
        localparam int         BAW = $clog2(DEP);

        conv_bank_sp #(
            .DW    (DW),
            .AW    (BAW),
            .DEPTH (DEP)
        ) u_bank (
            .clk       (clk),
            .i_we      (w_wr_ok && (csel == SEL)),
            .i_waddr   (caddr_wr[BAW-1:0]),
            .i_wdata   (cdata_wr),
            .i_re_a    (w_rd_ok && (csel == SEL)),
            .i_raddr_a (caddr_rd[BAW-1:0]),
            .o_rdata_a (w_q_a[g]),
            .i_re_b    (w_issue && (r_dsel == SEL)),
            .i_raddr_b (r_ptr[BAW-1:0]),
            .o_rdata_b (w_q_b[g])
        );
    end

    // A zero read select (reset or illegal read) forces cdata_rd to 0.
    always_comb begin
        cdata_rd = '0;
        w_dq     = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_rd_sel == 3'(i + 1)) begin
                cdata_rd = w_q_a[i];
            end
            if (r_dsel == 3'(i + 1)) begin
                w_dq = w_q_b[i];
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (busy) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                end else if (w_ptr_last) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_next  = S_IDLE;
                w_abort = busy;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_sel     <= '0;
            r_wr_l0      <= 1'b0;
            r_wr_l1      <= 1'b0;
            r_wr_l2      <= 1'b0;
            r_err        <= 1'b0;
            r_dsel       <= '0;
            r_ptr        <= '0;
            r_iss_vld    <= 1'b0;
            r_iss_addr   <= '0;
            r_iss_last   <= 1'b0;
            r_dump_vld   <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
            r_dump_abort <= 1'b0;
        end else begin
            if (crd) begin
                r_rd_sel <= w_rd_ok ? csel : 3'd0;
            end
            if (w_wr_ok) begin
                r_wr_l0 <= r_wr_l0 | (csel == CSEL_L0_0) | (csel == CSEL_L0_1);
                r_wr_l1 <= r_wr_l1 | (csel == CSEL_L1_0) | (csel == CSEL_L1_1);
                r_wr_l2 <= r_wr_l2 | (csel == CSEL_L2);
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_ptr  <= '0;
                r_dsel <= dump_sel;
            end else if (w_issue && !w_ptr_last) begin
                r_ptr <= r_ptr + 1'b1;
            end
            // Bank read of r_ptr lands one cycle later; this stage carries its tag.
            r_iss_vld    <= w_issue;
            r_iss_addr   <= r_ptr;
            r_iss_last   <= w_ptr_last;
            r_dump_abort <= w_abort;
            if (w_abort) begin
                r_dump_vld  <= 1'b0;
                r_dump_last <= 1'b0;
            end else begin
                r_dump_vld  <= r_iss_vld;
                r_dump_last <= r_iss_vld && r_iss_last;
                if (r_iss_vld) begin
                    r_dump_addr <= r_iss_addr;
                    r_dump_data <= w_dq;
                end
            end
        end
    end

    assign wr_l0      = r_wr_l0;
    assign wr_l1      = r_wr_l1;
    assign wr_l2      = r_wr_l2;
    assign err_acc    = r_err;
    assign dump_vld   = r_dump_vld;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_last;
    assign dump_abort = r_dump_abort;

endmodule

// File: tb/tb_conv_lmem_responder.sv
// Randomized bench for conv_lmem_responder against an array-based reference model.
module tb_conv_lmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy = 1'b0;
    logic [2:0]  csel = '0;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = '0;
    logic [19:0] cdata_wr = '0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = '0;
    logic [19:0] cdata_rd;
    logic        wr_l0, wr_l1, wr_l2, err_acc;
    logic        dump_start = 1'b0;
    logic [2:0]  dump_sel = '0;
    logic        dump_vld;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        dump_last;
    logic        dump_abort;

    conv_lmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy),
        .csel       (csel),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .wr_l0      (wr_l0),
        .wr_l1      (wr_l1),
        .wr_l2      (wr_l2),
        .err_acc    (err_acc),
        .dump_start (dump_start),
        .dump_sel   (dump_sel),
        .dump_vld   (dump_vld),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_abort (dump_abort)
    );

    always #5 clk = ~clk;

    logic [19:0] m [8][4096];
    logic [19:0] e_rd;
    logic        e_err, e_l0, e_l1, e_l2;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dep(input logic [2:0] cs);
        case (cs)
            3'd1, 3'd2: return 4096;
            3'd3, 3'd4: return 1024;
            3'd5:       return 2048;
            default:    return 0;
        endcase
    endfunction

    function automatic logic legal(input logic [2:0] cs, input logic [11:0] a);
        return int'(a) < dep(cs);
    endfunction

    function automatic logic [11:0] pick(input logic [2:0] cs);
        int idx;
        idx = $urandom_range(0, 19);
        if (idx < 16) return 12'(idx);
        return 12'(dep(cs) - 1 - (idx - 16));
    endfunction

    task automatic op(input logic [2:0] cs, input logic w, input logic [11:0] wa,
                      input logic [19:0] wd, input logic r, input logic [11:0] ra);
        csel = cs; cwr = w; caddr_wr = wa; cdata_wr = wd;
        crd = r; caddr_rd = ra;
        @(posedge clk); #1;
        if (r) begin
            if (legal(cs, ra)) e_rd = m[cs][ra];
            else begin e_rd = '0; e_err = 1'b1; end
        end
        if (w) begin
            if (legal(cs, wa)) begin
                m[cs][wa] = wd;
                if (cs == 3'd1 || cs == 3'd2) e_l0 = 1'b1;
                if (cs == 3'd3 || cs == 3'd4) e_l1 = 1'b1;
                if (cs == 3'd5) e_l2 = 1'b1;
            end else e_err = 1'b1;
        end
        cwr = 1'b0; crd = 1'b0;
        chk("cdata_rd", 32'(cdata_rd), 32'(e_rd));
        chk("err_acc", 32'(err_acc), 32'(e_err));
        chk("wr_l0", 32'(wr_l0), 32'(e_l0));
        chk("wr_l1", 32'(wr_l1), 32'(e_l1));
        chk("wr_l2", 32'(wr_l2), 32'(e_l2));
    endtask

    task automatic dump(input logic [2:0] sel, input int abort_at);
        int d;
        d = dep(sel);
        dump_sel = sel; dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        @(posedge clk); #1;
        chk("dump_vld_early", 32'(dump_vld), 0);
        for (int k = 0; k < d; k++) begin
            @(posedge clk); #1;
            chk("dump_vld", 32'(dump_vld), 1);
            chk("dump_addr", 32'(dump_addr), 32'(k));
            chk("dump_data", 32'(dump_data), 32'(m[sel][k]));
            chk("dump_last", 32'(dump_last), 32'(k == d - 1));
            chk("dump_abort_idle", 32'(dump_abort), 0);
            if (k == abort_at) begin
                busy = 1'b1;
                @(posedge clk); #1;
                chk("abort_vld", 32'(dump_vld), 0);
                chk("abort_last", 32'(dump_last), 0);
                chk("abort_pulse", 32'(dump_abort), 1);
                @(posedge clk); #1;
                chk("abort_pulse_end", 32'(dump_abort), 0);
                chk("abort_vld2", 32'(dump_vld), 0);
                return;
            end
        end
        @(posedge clk); #1;
        chk("dump_vld_end", 32'(dump_vld), 0);
        chk("dump_last_end", 32'(dump_last), 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_cdata_rd", 32'(cdata_rd), 0);
        chk("rst_wr_l0", 32'(wr_l0), 0);
        chk("rst_wr_l1", 32'(wr_l1), 0);
        chk("rst_wr_l2", 32'(wr_l2), 0);
        chk("rst_err_acc", 32'(err_acc), 0);
        chk("rst_dump_vld", 32'(dump_vld), 0);
        chk("rst_dump_addr", 32'(dump_addr), 0);
        chk("rst_dump_data", 32'(dump_data), 0);
        chk("rst_dump_last", 32'(dump_last), 0);
        chk("rst_dump_abort", 32'(dump_abort), 0);
    endtask

    initial begin
        logic [2:0]  cs;
        logic [11:0] wa, ra;
        e_rd = '0; e_err = 1'b0; e_l0 = 1'b0; e_l1 = 1'b0; e_l2 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();
        reset = 1'b1;
        busy = 1'b1;

        op(3'd1, 1'b1, 12'd4095, 20'hABCDE, 1'b0, 12'd0);
        op(3'd1, 1'b0, 12'd0, 20'h0, 1'b1, 12'd4095);
        chk("t1_data", 32'(cdata_rd), 32'h000ABCDE);

        op(3'd3, 1'b1, 12'd5, 20'h00007, 1'b0, 12'd0);
        op(3'd3, 1'b1, 12'd5, 20'h00001, 1'b1, 12'd5);
        chk("t2_old", 32'(cdata_rd), 32'h00007);
        op(3'd3, 1'b0, 12'd0, 20'h0, 1'b1, 12'd5);
        chk("t2_new", 32'(cdata_rd), 32'h00001);

        op(3'd3, 1'b1, 12'd0, 20'h12345, 1'b0, 12'd0);
        chk("t3_err_clear", 32'(err_acc), 0);
        op(3'd3, 1'b1, 12'd1024, 20'hFFFFF, 1'b0, 12'd0);
        chk("t3_err_set", 32'(err_acc), 1);
        op(3'd6, 1'b0, 12'd0, 20'h0, 1'b1, 12'd0);
        chk("t3_bad_rd", 32'(cdata_rd), 0);
        op(3'd3, 1'b0, 12'd0, 20'h0, 1'b1, 12'd0);
        chk("t3_no_alias", 32'(cdata_rd), 32'h12345);

        for (int b = 1; b <= 5; b++) begin
            for (int i = 0; i < 20; i++) begin
                wa = (i < 16) ? 12'(i) : 12'(dep(3'(b)) - 1 - (i - 16));
                op(3'(b), 1'b1, wa, 20'($urandom), 1'b0, 12'd0);
            end
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) != 0) begin
                cs = 3'($urandom_range(1, 5));
                wa = pick(cs);
                ra = pick(cs);
            end else if ($urandom_range(0, 1) == 0) begin
                cs = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(6, 7));
                wa = 12'($urandom);
                ra = 12'($urandom);
            end else begin
                cs = 3'($urandom_range(3, 5));
                wa = 12'(dep(cs) + $urandom_range(0, 4095 - dep(cs)));
                ra = 12'(dep(cs) + $urandom_range(0, 4095 - dep(cs)));
            end
            op(cs, 1'($urandom), wa, 20'($urandom), 1'($urandom), ra);
        end

        for (int a = 0; a < 2048; a++) begin
            op(3'd5, 1'b1, 12'(a), 20'(a), 1'b0, 12'd0);
        end
        busy = 1'b0;
        dump(3'd5, -1);

        dump(3'd4, 10);
        dump_sel = 3'd4; dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("busy_start_vld", 32'(dump_vld), 0);
        end
        busy = 1'b0;

        dump_sel = 3'd5; dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_running", 32'(dump_vld), 1);
        #3 reset = 1'b0;
        #1;
        chk_reset_outs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();
        reset = 1'b1;
        e_rd = '0; e_err = 1'b0; e_l0 = 1'b0; e_l1 = 1'b0; e_l2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t6_no_resume", 32'(dump_vld), 0);
        end
        op(3'd5, 1'b0, 12'd0, 20'h0, 1'b1, 12'd100);
        chk("t6_keep_l2", 32'(cdata_rd), 32'd100);
        op(3'd5, 1'b0, 12'd0, 20'h0, 1'b1, 12'd2047);
        op(3'd1, 1'b0, 12'd0, 20'h0, 1'b1, 12'd4095);
        op(3'd3, 1'b0, 12'd0, 20'h0, 1'b1, 12'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
